prefetch_request_queue: RTL

Sits directly downstream of the data prefetcher. It accepts cache-line prefetch requests over a valid/ready handshake, drops duplicates, and holds accepted requests in a small entry buffer. It issues them to the memory interface with bounded concurrency, then returns a per-line acknowledgement to the prefetcher when each fill completes.

---
 rtl/prefetch_request_queue.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/prefetch_request_queue.sv
// Prefetch request queue: dedups line requests, issues them to memory with a
// bounded number in flight, and acks each line when its fill returns.
// Optional saturating stat counters are enabled by defining PREFETCH_QUEUE_STATS_EN.
module prefetch_request_queue #(
    parameter int DEPTH        = 4,
    parameter int CL_E         = 6,
    parameter int LINE_W       = 26,
    parameter int MAX_INFLIGHT = 2,
    parameter int ID_W         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IN_prefetch_valid,
    input  logic [LINE_W-1:0] IN_prefetch_addr,
    output logic              OUT_prefetchReady,
    output logic              OUT_ack_valid,
    output logic [LINE_W-1:0] OUT_ack_addr,
    output logic              OUT_memReq_valid,
    output logic [31:0]       OUT_memReq_addr,
    output logic [ID_W-1:0]   OUT_memReq_id,
    input  logic              IN_memReq_ready,
    input  logic              IN_memResp_valid,
    input  logic [ID_W-1:0]   IN_memResp_id,
    output logic [15:0]       OUT_statAccepted,
    output logic [15:0]       OUT_statDropped
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_FREE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_ISSUED  = 2'd2
    } ent_state_e;

    ent_state_e        state_q [DEPTH];
    ent_state_e        state_d [DEPTH];
    logic [LINE_W-1:0] addr_q  [DEPTH];
    logic [LINE_W-1:0] addr_d  [DEPTH];
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic              ack_vld_q, ack_vld_d;
    logic [LINE_W-1:0] ack_addr_q, ack_addr_d;

    logic              any_free;
    logic [ID_W-1:0]   alloc_idx;
    logic              any_pend;
    logic [ID_W-1:0]   pend_idx;
    logic [LINE_W-1:0] pend_addr;
    logic              dup_hit;
    logic              accept;
    logic              alloc;
    logic              drop;
    logic              issue;
    logic              complete;

    // Lowest-index FREE and PENDING entries, taken from registered state only
    always_comb begin
        any_free  = 1'b0;
        alloc_idx = '0;
        any_pend  = 1'b0;
        pend_idx  = '0;
        pend_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!any_free && state_q[i] == ST_FREE) begin
                any_free  = 1'b1;
                alloc_idx = ID_W'(i);
            end
            if (!any_pend && state_q[i] == ST_PENDING) begin
                any_pend  = 1'b1;
                pend_idx  = ID_W'(i);
                pend_addr = addr_q[i];
            end
        end
    end

    // An entry completing this cycle is still non-FREE here, so it still dedups
    always_comb begin
        dup_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (state_q[i] != ST_FREE && addr_q[i] == IN_prefetch_addr) begin
                dup_hit = 1'b1;
            end
        end
    end

    assign OUT_prefetchReady = any_free && !rst;
    assign OUT_memReq_valid  = any_pend && (inflight_q < CNT_W'(MAX_INFLIGHT));
    assign OUT_memReq_addr   = {pend_addr, {CL_E{1'b0}}};
    assign OUT_memReq_id     = pend_idx;
    assign OUT_ack_valid     = ack_vld_q;
    assign OUT_ack_addr      = ack_addr_q;

    assign accept   = IN_prefetch_valid && OUT_prefetchReady;
    assign alloc    = accept && !dup_hit;
    assign drop     = accept && dup_hit;
    assign issue    = OUT_memReq_valid && IN_memReq_ready;
    assign complete = IN_memResp_valid && (state_q[IN_memResp_id] == ST_ISSUED);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            state_d[i] = state_q[i];
            addr_d[i]  = addr_q[i];
        end
        inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(complete);
        ack_vld_d  = complete;
        ack_addr_d = complete ? addr_q[IN_memResp_id] : '0;

        if (issue) begin
            state_d[pend_idx] = ST_ISSUED;
        end
        if (complete) begin
            state_d[IN_memResp_id] = ST_FREE;
        end
        // alloc_idx was FREE in registered state, so it never collides with issue/complete
        if (alloc) begin
            state_d[alloc_idx] = ST_PENDING;
            addr_d[alloc_idx]  = IN_prefetch_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= ST_FREE;
                addr_q[i]  <= '0;
            end
            inflight_q <= '0;
            ack_vld_q  <= 1'b0;
            ack_addr_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= state_d[i];
                addr_q[i]  <= addr_d[i];
            end
            inflight_q <= inflight_d;
            ack_vld_q  <= ack_vld_d;
            ack_addr_q <= ack_addr_d;
        end
    end

`ifdef PREFETCH_QUEUE_STATS_EN
    logic [15:0] stat_acc_q, stat_acc_d;
    logic [15:0] stat_drop_q, stat_drop_d;

    always_comb begin
        stat_acc_d  = stat_acc_q;
        stat_drop_d = stat_drop_q;
        if (alloc && stat_acc_q != 16'hFFFF) begin
            stat_acc_d = stat_acc_q + 16'd1;
        end
        if (drop && stat_drop_q != 16'hFFFF) begin
            stat_drop_d = stat_drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_acc_q  <= '0;
            stat_drop_q <= '0;
        end else begin
            stat_acc_q  <= stat_acc_d;
            stat_drop_q <= stat_drop_d;
        end
    end

    assign OUT_statAccepted = stat_acc_q;
    assign OUT_statDropped  = stat_drop_q;
`else
    logic unused_drop;
    assign unused_drop      = drop;
    assign OUT_statAccepted = 16'd0;
    assign OUT_statDropped  = 16'd0;
`endif

endmodule
